// File: rtl/barcode_pkg.sv
// barcode_pkg: state encoding, fixed bar symbols and the 2-of-5 digit encoder.
// The encoder is shared with the reader side so both use one decode table.
package barcode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_DIGIT,
        ST_CHECK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [4:0] SYM_START = 5'b11111;
    localparam logic [4:0] SYM_STOP  = 5'b10101;
    localparam logic [4:0] SYM_GAP   = 5'b00000;

    // Line weights [4:0] = 7,4,2,1,0; exactly two bars set per digit.
    function automatic logic [4:0] encode_2of5(input logic [3:0] d);
        case (d)
            4'd0:    encode_2of5 = 5'b11000;
            4'd1:    encode_2of5 = 5'b00011;
            4'd2:    encode_2of5 = 5'b00101;
            4'd3:    encode_2of5 = 5'b00110;
            4'd4:    encode_2of5 = 5'b01001;
            4'd5:    encode_2of5 = 5'b01010;
            4'd6:    encode_2of5 = 5'b01100;
            4'd7:    encode_2of5 = 5'b10001;
            4'd8:    encode_2of5 = 5'b10010;
            4'd9:    encode_2of5 = 5'b10100;
            default: encode_2of5 = SYM_GAP;
        endcase
    endfunction

endpackage

// File: rtl/barcode_digit_fifo.sv
// barcode_digit_fifo: DEPTH x 4-bit digit buffer, show-ahead read (dout is the
// oldest entry). Pointers wrap modulo DEPTH (DEPTH is a power of two).
module barcode_digit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [3:0]                 din,
    input  logic                       pop,
    output logic [3:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/barcode_emitter.sv
// barcode_emitter: buffers BCD digits and serialises them as a 2-of-5 frame
// START, digits, [CHECK], STOP with a GAP after every symbol except STOP.
// Optional feature macro: BARCODE_CHECKSUM_EN adds a mod-10 check symbol.
module barcode_emitter
    import barcode_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       din_err,
    input  logic       start,
    output logic       busy,
    output logic [4:0] bar,
    output logic       bar_valid,
    output logic       done
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic            hold_last;
    logic            digit_ok;
    logic            fifo_push;
    logic            fifo_pop;
    logic            start_ok;
    logic [3:0]      head;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

`ifdef BARCODE_CHECKSUM_EN
    logic [3:0] sum;
    logic [4:0] sum_add;
    logic [3:0] check_digit;
    logic       check_sent;

    assign sum_add     = {1'b0, sum} + {1'b0, head};
    assign check_digit = (sum == 4'd0) ? 4'd0 : 4'd10 - sum;
`endif

    assign digit_ok  = (din <= 4'd9);
    assign din_ready = (state == ST_IDLE) && !full;
    assign fifo_push = din_valid && din_ready && digit_ok;
    // A digit pushed in the same cycle as start counts toward a non-empty buffer.
    assign start_ok  = (state == ST_IDLE) && start && ((count != '0) || fifo_push);
    assign fifo_pop  = (state == ST_DIGIT) && hold_last;
    assign hold_last = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);

    barcode_digit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (din),
        .pop   (fifo_pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Hold counter restarts on every state change; every timed state is
    // always followed by a different state, so this marks symbol boundaries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  hold_cnt <= '0;
        else if (state_nxt != state) hold_cnt <= '0;
        else if (busy)               hold_cnt <= hold_cnt + 1'b1;
    end

    // Bad-digit flag pulses the cycle after the rejected push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) din_err <= 1'b0;
        else        din_err <= din_valid && din_ready && !digit_ok;
    end

`ifdef BARCODE_CHECKSUM_EN
    // Running mod-10 sum of sent digits, and whether CHECK went out this frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum        <= '0;
            check_sent <= 1'b0;
        end else if (start_ok) begin
            sum        <= '0;
            check_sent <= 1'b0;
        end else begin
            if (fifo_pop)           sum <= (sum_add >= 5'd10) ? 4'(sum_add - 5'd10) : sum_add[3:0];
            if (state == ST_CHECK)  check_sent <= 1'b1;
        end
    end
`endif

    // Next-state: the GAP decides what follows from the buffer and check status.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok)  state_nxt = ST_START;
            ST_START: if (hold_last) state_nxt = ST_GAP;
            ST_GAP: begin
                if (hold_last) begin
                    if (!empty) state_nxt = ST_DIGIT;
`ifdef BARCODE_CHECKSUM_EN
                    else if (!check_sent) state_nxt = ST_CHECK;
`endif
                    else state_nxt = ST_STOP;
                end
            end
            ST_DIGIT: if (hold_last) state_nxt = ST_GAP;
`ifdef BARCODE_CHECKSUM_EN
            ST_CHECK: if (hold_last) state_nxt = ST_GAP;
`endif
            ST_STOP:  if (hold_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bus symbol and strobes decoded from the current state.
    always_comb begin
        bar       = SYM_GAP;
        bar_valid = 1'b0;
        done      = 1'b0;
        case (state)
            ST_START: begin bar = SYM_START;         bar_valid = 1'b1; end
            ST_DIGIT: begin bar = encode_2of5(head); bar_valid = 1'b1; end
`ifdef BARCODE_CHECKSUM_EN
            ST_CHECK: begin bar = encode_2of5(check_digit); bar_valid = 1'b1; end
`endif
            ST_STOP:  begin bar = SYM_STOP;          bar_valid = 1'b1; end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_barcode_emitter.sv
// tb_barcode_emitter: random digit strings checked cycle by cycle against a
// frame model built from the symbol table and frame layout.
module tb_barcode_emitter;
    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       din_err;
    logic       start = 1'b0;
    logic       busy;
    logic [4:0] bar;
    logic       bar_valid;
    logic       done;

    int total = 0;
    int bad   = 0;
    int q[$];
    logic [4:0] enc_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                 5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    barcode_emitter #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_err   (din_err),
        .start     (start),
        .busy      (busy),
        .bar       (bar),
        .bar_valid (bar_valid),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Push one value while idle; model appends it only if legal and not full.
    task automatic push(input int d);
        bit rdy;
        rdy = (q.size() < DEPTH);
        chk("din_ready", din_ready, rdy);
        din = 4'(d);
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        if (rdy && d <= 9) q.push_back(d);
        chk("din_err", din_err, rdy && d > 9);
    endtask

    // Start a frame from the model buffer and check every cycle through DONE.
    task automatic run_frame(input bit noise);
        logic [5:0] exp[$];
        int sum;
        sum = 0;
        for (int h = 0; h < HOLD; h++) exp.push_back({1'b1, 5'b11111});
        for (int h = 0; h < HOLD; h++) exp.push_back({1'b0, 5'b00000});
        foreach (q[i]) begin
            sum += q[i];
            for (int h = 0; h < HOLD; h++) exp.push_back({1'b1, enc_tab[q[i]]});
            for (int h = 0; h < HOLD; h++) exp.push_back({1'b0, 5'b00000});
        end
`ifdef BARCODE_CHECKSUM_EN
        for (int h = 0; h < HOLD; h++) exp.push_back({1'b1, enc_tab[(10 - sum % 10) % 10]});
        for (int h = 0; h < HOLD; h++) exp.push_back({1'b0, 5'b00000});
`endif
        for (int h = 0; h < HOLD; h++) exp.push_back({1'b1, 5'b10101});
        start = 1'b1;
        foreach (exp[i]) begin
            step();
            start = 1'b0;
            din_valid = 1'b0;
            if (noise) begin
                start     = 1'($urandom);
                din_valid = 1'($urandom);
                din       = 4'($urandom_range(0, 9));
            end
            chk("bar", bar, exp[i][4:0]);
            chk("bar_valid", bar_valid, exp[i][5]);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("ready_busy", din_ready, 0);
        end
        start = 1'b0;
        din_valid = 1'b0;
        step();
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("bar_done", bar, 0);
        chk("bar_valid_done", bar_valid, 0);
        step();
        chk("done_once", done, 0);
        chk("ready_after", din_ready, 1);
        q.delete();
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_bar", bar, 0);
        chk("rst_bar_valid", bar_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", din_err, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_ready", din_ready, 1);

        // directed frame: 3,7
        push(3);
        push(7);
        run_frame(1'b0);

        // illegal digit then empty start
        push(12);
        step();
        chk("din_err_clear", din_err, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_start_busy", busy, 0);
        step();
        chk("empty_start_valid", bar_valid, 0);

        // push in the same cycle as start on an empty buffer
        q.push_back(6);
        din = 4'd6;
        din_valid = 1'b1;
        run_frame(1'b0);

        // fill to full; 9th push ignored
        for (int i = 0; i < DEPTH + 1; i++) push($urandom_range(0, 9));
        chk("full_ready", din_ready, 0);
        run_frame(1'b1);

        // random frames with occasional illegal pushes and busy noise
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 4) == 0) push($urandom_range(10, 15));
                push($urandom_range(0, 9));
            end
            run_frame(1'(it));
        end

        // reset during the second digit
        push(5);
        push(2);
        push(9);
        start = 1'b1;
        for (int i = 0; i < 4 * HOLD + 1; i++) begin
            step();
            start = 1'b0;
        end
        chk("mid_digit2", bar, enc_tab[2]);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_bar", bar, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", bar_valid, 0);
        chk("mid_rst_done", done, 0);
        q.delete();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_ready", din_ready, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("discarded_busy", busy, 0);

        // a clean frame after the aborted one
        push(1);
        push(4);
        run_frame(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
